sd_sec_reader: RTL and testbench

SPI-mode SD sector-read engine that fetches one 512-byte block per request and streams it out byte by byte. It sits directly below the AHB SD card interface: it consumes `sd_sec_read`/`sd_sec_read_addr` and produces the `sd_sec_read_data`/`_valid`/`_end` stream that the interface writes into its sector buffer. Card power-up and initialisation are handled by a separate init block. This block only reads from an already-initialised card, signalled by `sd_init_done`.

---
 rtl/sd_sec_reader.sv | 185 ++++++++++++++++++
 tb/tb_sd_sec_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sec_reader.sv
// rtl/sd_sec_reader.sv - SPI-mode SD single-block sector read engine
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   sd_init_done             : card initialised; requests accepted only while high
//   sd_sec_read, _addr       : request level (held until _end) and block address
//   sd_sec_read_data, _valid : received data byte and its one-cycle strobe
//   sd_sec_read_end, _err    : one-cycle completion strobe; _err marks a failure
//   SD_nCS/DCLK/MOSI/MISO    : SPI mode 0 card interface, MSB first
module sd_sec_reader #(
  parameter int CLK_DIV       = 4,
  parameter int R1_TIMEOUT    = 16,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        sd_sec_read,
  input  logic [31:0] sd_sec_read_addr,
  output logic [7:0]  sd_sec_read_data,
  output logic        sd_sec_read_data_valid,
  output logic        sd_sec_read_end,
  output logic        sd_sec_read_err,
  output logic        SD_nCS,
  output logic        SD_DCLK,
  output logic        SD_MOSI,
  input  logic        SD_MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] R1_LIM  = 16'(R1_TIMEOUT);
  localparam logic [15:0] TOK_LIM = 16'(TOKEN_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL, S_DONE, S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [31:0] addr_q;
  logic [15:0] cnt, cnt_nxt;   // bytes finished in the current state
  logic        err_q, err_set;

  // byte engine
  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       half_cnt;  // even: next tick is a rising edge, odd: falling
  logic [7:0]       tx_sr, rx_sr, tx_nxt;
  logic             tick, rise_tick, last_rise, byte_fin, start, run_nxt;

  assign tick      = busy && (div_cnt == DIV_LAST);
  assign rise_tick = tick && !half_cnt[0];
  assign last_rise = tick && (half_cnt == 4'd14);
  assign byte_fin  = tick && (half_cnt == 4'd15);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 16'd0;
      err_q  <= 1'b0;
      addr_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && state_nxt == S_CMD) begin
        addr_q <= sd_sec_read_addr;
        err_q  <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // next state: byte-driven states only move when a byte has fully finished
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      S_IDLE:  if (sd_sec_read && sd_init_done) state_nxt = S_CMD;
      S_CMD:   if (byte_fin && cnt == 16'd5) state_nxt = S_R1;
      S_R1:
        if (byte_fin) begin
          if (rx_sr == 8'h00) begin
            state_nxt = S_TOKEN;
          end else if (rx_sr != 8'hFF || cnt >= R1_LIM) begin
            state_nxt = S_TAIL;
            err_set   = 1'b1;
          end
        end
      S_TOKEN:
        if (byte_fin) begin
          if (rx_sr == 8'hFE) begin
            state_nxt = S_DATA;
          end else if (rx_sr != 8'hFF || cnt >= TOK_LIM) begin
            state_nxt = S_TAIL;
            err_set   = 1'b1;
          end
        end
      S_DATA:  if (byte_fin && cnt == 16'd511) state_nxt = S_CRC;
      S_CRC:   if (byte_fin && cnt == 16'd1) state_nxt = S_TAIL;
      S_TAIL:  if (byte_fin) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_HOLD;
      S_HOLD:  if (!sd_sec_read) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && !sd_init_done) state_nxt = S_IDLE;
  end

  // outputs decoded from state
  always_comb begin
    SD_nCS          = !(state inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC});
    sd_sec_read_end = (state == S_DONE);
    sd_sec_read_err = (state == S_DONE) && err_q;
  end

  // byte counter and the byte to transmit next
  always_comb begin
    if (state_nxt != state) cnt_nxt = 16'd0;
    else if (byte_fin)      cnt_nxt = cnt + 16'd1;
    else                    cnt_nxt = cnt;

    run_nxt = state_nxt inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TAIL};
    // a new byte begins on acceptance or directly on the last falling edge
    start   = run_nxt && (state == S_IDLE || byte_fin);

    tx_nxt = 8'hFF;
    if (state_nxt == S_CMD) begin
      case (cnt_nxt[2:0])
        3'd0:    tx_nxt = 8'h51;
        3'd1:    tx_nxt = addr_q[31:24];
        3'd2:    tx_nxt = addr_q[23:16];
        3'd3:    tx_nxt = addr_q[15:8];
        3'd4:    tx_nxt = addr_q[7:0];
        default: tx_nxt = 8'hFF;
      endcase
    end
  end

  // shared SPI byte engine: MOSI updates on falling edges, MISO sampled on rising
  always_ff @(posedge clk) begin
    if (rst || !run_nxt) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= 4'd0;
      SD_DCLK  <= 1'b0;
      SD_MOSI  <= 1'b1;
      tx_sr    <= 8'hFF;
      rx_sr    <= 8'hFF;
    end else if (start) begin
      busy     <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= 4'd0;
      SD_DCLK  <= 1'b0;
      SD_MOSI  <= tx_nxt[7];
      tx_sr    <= {tx_nxt[6:0], 1'b1};
    end else if (busy) begin
      if (tick) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 4'd1;
        SD_DCLK  <= rise_tick;
        if (rise_tick) begin
          rx_sr <= {rx_sr[6:0], SD_MISO};
        end else begin
          SD_MOSI <= tx_sr[7];
          tx_sr   <= {tx_sr[6:0], 1'b1};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // data byte is complete at the 8th rising sample
  always_ff @(posedge clk) begin
    if (rst) begin
      sd_sec_read_data       <= 8'h00;
      sd_sec_read_data_valid <= 1'b0;
    end else begin
      sd_sec_read_data_valid <= last_rise && (state == S_DATA) && sd_init_done;
      if (last_rise && state == S_DATA) sd_sec_read_data <= {rx_sr[6:0], SD_MISO};
    end
  end

endmodule

// File: tb/tb_sd_sec_reader.sv
// tb/tb_sd_sec_reader.sv - directed bench for sd_sec_reader with an SPI card model
module tb_sd_sec_reader;

  localparam int R1_TO  = 16;
  localparam int TOK_TO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init_done;
  logic [31:0] addr;
  logic        rd [2];
  logic [7:0]  data [2];
  logic        valid [2], s_end [2], s_err [2], ncs [2], dclk [2], mosi [2], miso [2];
  logic        model_miso;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sd_sec_reader #(
      .CLK_DIV(g == 0 ? 2 : 1), .R1_TIMEOUT(R1_TO), .TOKEN_TIMEOUT(TOK_TO)
    ) u_dut (
      .clk(clk), .rst(rst), .sd_init_done(init_done),
      .sd_sec_read(rd[g]), .sd_sec_read_addr(addr),
      .sd_sec_read_data(data[g]), .sd_sec_read_data_valid(valid[g]),
      .sd_sec_read_end(s_end[g]), .sd_sec_read_err(s_err[g]),
      .SD_nCS(ncs[g]), .SD_DCLK(dclk[g]), .SD_MOSI(mosi[g]), .SD_MISO(miso[g])
    );
    assign miso[g] = model_miso;
  end

  logic       sel;
  logic       cur_dclk, cur_ncs, cur_mosi, cur_valid, cur_end, cur_err;
  logic [7:0] cur_data;
  assign cur_dclk  = dclk[sel];
  assign cur_ncs   = ncs[sel];
  assign cur_mosi  = mosi[sel];
  assign cur_valid = valid[sel];
  assign cur_end   = s_end[sel];
  assign cur_err   = s_err[sel];
  assign cur_data  = data[sel];

  typedef struct {
    logic [31:0] addr;
    int          r1_ff;
    logic [7:0]  r1_val;
    int          tok_ff;
    logic [7:0]  tok_val;
    bit          r1_stuck;
    bit          tok_stuck;
    int          exp_valid;
    int          exp_err;
    int          exp_bytes;
  } vec_t;

  vec_t vecs [6];
  int checks = 0, errors = 0;

  // card model
  int         r1_ff, tok_ff, midx, mbit;
  logic [7:0] r1_val, tok_val, cur_byte;
  bit         r1_stuck, tok_stuck;

  function automatic logic [7:0] resp(int idx);
    int j, k, d;
    j = idx - 6;
    if (j < 0 || r1_stuck || j < r1_ff) return 8'hFF;
    if (j == r1_ff) return r1_val;
    k = j - r1_ff - 1;
    if (tok_stuck || k < tok_ff) return 8'hFF;
    if (k == tok_ff) return tok_val;
    d = k - tok_ff - 1;
    if (d < 512) return d[7:0];
    return 8'hFF;
  endfunction

  always @(negedge cur_dclk) begin
    mbit = mbit + 1;
    if (mbit == 8) begin
      mbit = 0;
      midx = midx + 1;
    end
    cur_byte   = resp(midx);
    model_miso = cur_byte[7 - mbit];
  end

  // monitors
  int         nvalid, nend, bad_data, stray_err, ncs_falls, ncs_low_end, end_err_cnt, mo_bits;
  logic       ncs_q;
  logic [7:0] mo_sr;
  logic [7:0] mo_bytes [7];

  always @(posedge cur_dclk) begin
    if (!cur_ncs) begin
      mo_sr   = {mo_sr[6:0], cur_mosi};
      mo_bits = mo_bits + 1;
      if (mo_bits % 8 == 0 && mo_bits / 8 <= 7) mo_bytes[mo_bits / 8 - 1] = mo_sr;
    end
  end

  always @(negedge clk) begin
    if (cur_valid) begin
      if (cur_data !== 8'(nvalid)) bad_data = bad_data + 1;
      nvalid = nvalid + 1;
    end
    if (cur_end) begin
      nend = nend + 1;
      if (!cur_ncs) ncs_low_end = ncs_low_end + 1;
      if (cur_err) end_err_cnt = end_err_cnt + 1;
    end
    if (cur_err && !cur_end) stray_err = stray_err + 1;
    if (ncs_q && !cur_ncs) ncs_falls = ncs_falls + 1;
    ncs_q = cur_ncs;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    nvalid = 0; nend = 0; bad_data = 0; stray_err = 0; ncs_falls = 0;
    ncs_low_end = 0; end_err_cnt = 0; mo_bits = 0; mo_sr = 8'h00; ncs_q = 1'b1;
    for (int i = 0; i < 7; i++) mo_bytes[i] = 8'h00;
  endtask

  task automatic set_model(vec_t v);
    r1_ff = v.r1_ff; r1_val = v.r1_val; tok_ff = v.tok_ff; tok_val = v.tok_val;
    r1_stuck = v.r1_stuck; tok_stuck = v.tok_stuck;
    midx = 0; mbit = 0; model_miso = 1'b1;
  endtask

  task automatic check_reset(int u);
    chk("rst_ncs", 32'(ncs[u]), 1);
    chk("rst_dclk", 32'(dclk[u]), 0);
    chk("rst_mosi", 32'(mosi[u]), 1);
    chk("rst_data", 32'(data[u]), 0);
    chk("rst_valid", 32'(valid[u]), 0);
    chk("rst_end", 32'(s_end[u]), 0);
    chk("rst_err", 32'(s_err[u]), 0);
  endtask

  // full request: acceptance timing, completion, 50-cycle held request, release
  task automatic run_vec(vec_t v, int div);
    int n;
    logic [7:0] e [7];
    set_model(v);
    clear_mon();
    addr = v.addr;
    rd[sel] = 1'b1;
    @(negedge clk);
    chk("ncs_fall_1cyc", 32'(cur_ncs), 0);
    n = 0;
    while (!cur_dclk && n < 100) begin @(negedge clk); n++; end
    chk("first_rise_delay", n, div);
    addr = ~v.addr;
    n = 0;
    while (cur_dclk && n < 100) begin @(negedge clk); n++; end
    while (!cur_dclk && n < 100) begin @(negedge clk); n++; end
    chk("dclk_period", n, 2 * div);
    n = 0;
    while (nend == 0 && n < 40000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    rd[sel] = 1'b0;
    repeat (5) @(negedge clk);
    chk("end_count", nend, 1);
    chk("err_at_end", end_err_cnt, v.exp_err);
    chk("stray_err", stray_err, 0);
    chk("valid_count", nvalid, v.exp_valid);
    chk("data_mismatches", bad_data, 0);
    chk("ncs_low_at_end", ncs_low_end, 0);
    chk("bytes_clocked", mo_bits / 8, v.exp_bytes);
    chk("cmd_issued_once", ncs_falls, 1);
    chk("idle_ncs", 32'(cur_ncs), 1);
    e = '{8'h51, v.addr[31:24], v.addr[23:16], v.addr[15:8], v.addr[7:0], 8'hFF, 8'hFF};
    for (int i = 0; i < 7; i++) chk($sformatf("mosi_byte%0d", i), 32'(mo_bytes[i]), 32'(e[i]));
  endtask

  initial begin
    int n, k;
    vec_t v;
    //          addr          r1ff r1   tokff tok    r1s tks valid err bytes
    vecs[0] = '{32'h00001234, 2,  8'h00, 10, 8'hFE, 0, 0, 512, 0, 534};
    vecs[1] = '{32'h0000ABCD, 1,  8'h05, 0,  8'hFE, 0, 0, 0,   1, 8};
    vecs[2] = '{32'h12345678, 0,  8'h00, 0,  8'hFE, 1, 0, 0,   1, 6 + R1_TO + 1};
    vecs[3] = '{32'h00000007, 0,  8'h00, 0,  8'hFE, 0, 1, 0,   1, 6 + 1 + TOK_TO + 1};
    vecs[4] = '{32'h80000001, 0,  8'h00, 3,  8'h08, 0, 0, 0,   1, 11};
    vecs[5] = '{32'h00000010, R1_TO, 8'h00, TOK_TO, 8'h08, 0, 0, 0, 1, 6 + R1_TO + 1 + TOK_TO + 1};

    sel = 1'b0; rst = 1'b1; init_done = 1'b1; addr = 32'd0;
    rd[0] = 1'b0; rd[1] = 1'b0;
    set_model(vecs[0]);
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 2);

    // reset during data byte 100, then a clean read at address 0
    set_model(vecs[0]);
    clear_mon();
    addr = 32'h00001234;
    rd[0] = 1'b1;
    n = 0;
    while (nvalid < 100 && n < 40000) begin @(negedge clk); n++; end
    chk("abort_reached_byte100", 32'(nvalid >= 100), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    rst = 1'b0; rd[0] = 1'b0;
    repeat (3) @(negedge clk);
    v = vecs[0];
    v.addr = 32'h0;
    run_vec(v, 2);

    // init loss mid-data: immediate idle, no end strobe
    set_model(vecs[0]);
    clear_mon();
    rd[0] = 1'b1;
    n = 0;
    while (nvalid < 5 && n < 40000) begin @(negedge clk); n++; end
    init_done = 1'b0;
    @(negedge clk);
    chk("initloss_ncs", 32'(ncs[0]), 1);
    chk("initloss_dclk", 32'(dclk[0]), 0);
    k = nvalid;
    repeat (100) @(negedge clk);
    chk("initloss_no_end", nend, 0);
    chk("initloss_no_valid", nvalid, k);
    init_done = 1'b1; rd[0] = 1'b0;
    repeat (3) @(negedge clk);

    // fastest divider, normal read
    sel = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
